// File: rtl/minmax_frame_ctrl.sv
// Frame-level min/max controller: folds per-block extrema from a combinational
// minmax core into one frame extremum tagged with its global element index.

module minmax_core #(
    parameter int W       = 5,
    parameter int NI      = 9,
    parameter int IDXW    = $clog2(NI),
    parameter int OUT_CFG = 0,
    parameter int MM_CFG  = 0
) (
    input  logic [NI*W-1:0] data,
    input  logic            us_sel,
    input  logic            min_max_sel,
    output logic [W-1:0]    result,
    output logic [IDXW-1:0] index
);
    // MM_CFG: 0 = runtime select, 1 = fixed min, 2 = fixed max.
    // OUT_CFG: 0 = value and index, otherwise index only (value forced to zero).
    function automatic logic is_better(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic us, input logic mx);
        logic gt;
        logic lt;
        if (us) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return mx ? gt : lt;
    endfunction

    logic            mx_s;
    logic            upd_s;
    logic [W-1:0]    best_val_s;
    logic [IDXW-1:0] best_idx_s;

    // Linear scan; strict compare keeps the lowest local index on ties.
    always_comb begin
        mx_s       = (MM_CFG == 0) ? min_max_sel : (MM_CFG == 2);
        upd_s      = 1'b0;
        best_val_s = data[W-1:0];
        best_idx_s = {IDXW{1'b0}};
        for (int i = 1; i < NI; i++) begin
            upd_s      = is_better(data[i*W +: W], best_val_s, us_sel, mx_s);
            best_val_s = upd_s ? data[i*W +: W] : best_val_s;
            best_idx_s = upd_s ? IDXW'(i) : best_idx_s;
        end
    end

    assign result = (OUT_CFG == 0) ? best_val_s : {W{1'b0}};
    assign index  = best_idx_s;
endmodule

module minmax_frame_ctrl #(
    parameter int W        = 5,
    parameter int NI       = 9,
    parameter int IDXW     = $clog2(NI),
    parameter int NBLK_MAX = 16,
    parameter int GIDXW    = $clog2(NI*NBLK_MAX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic [$clog2(NBLK_MAX):0] cfg_nblk,
    input  logic                      cfg_us_sel,
    input  logic                      cfg_min_max_sel,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [NI*W-1:0]           s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [W-1:0]              m_result,
    output logic [GIDXW-1:0]          m_index,
    output logic                      busy
);
    localparam int NBW = $clog2(NBLK_MAX) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic logic is_better(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic us, input logic mx);
        logic gt;
        logic lt;
        if (us) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return mx ? gt : lt;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [NBW-1:0]   nblk_r;
    logic [NBW-1:0]   blk_cnt_r;
    logic             us_r;
    logic             mm_r;
    logic [W-1:0]     acc_val_r;
    logic [W-1:0]     acc_val_s;
    logic [GIDXW-1:0] acc_idx_r;
    logic [GIDXW-1:0] acc_idx_s;
    logic             s_ready_r;
    logic             m_valid_r;
    logic             busy_r;
    logic [W-1:0]     m_result_r;
    logic [GIDXW-1:0] m_index_r;
    logic [W-1:0]     core_val_s;
    logic [IDXW-1:0]  core_idx_s;
    logic             beat_s;
    logic             last_s;
    logic             start_ok_s;
    logic             cand_better_s;
    logic [GIDXW-1:0] cand_idx_s;

    minmax_core #(
        .W(W), .NI(NI), .IDXW(IDXW), .OUT_CFG(0), .MM_CFG(0)
    ) u_core (
        .data        (s_data),
        .us_sel      (us_r),
        .min_max_sel (mm_r),
        .result      (core_val_s),
        .index       (core_idx_s)
    );

    // Beat qualification and accumulator fold; block 0 always loads.
    always_comb begin
        start_ok_s    = cfg_start && (cfg_nblk != {NBW{1'b0}}) && (cfg_nblk <= NBW'(NBLK_MAX));
        beat_s        = s_valid && s_ready_r;
        last_s        = (blk_cnt_r == (nblk_r - NBW'(1'b1)));
        cand_idx_s    = GIDXW'(blk_cnt_r) * GIDXW'(NI) + GIDXW'(core_idx_s);
        cand_better_s = is_better(core_val_s, acc_val_r, us_r, mm_r);
        if (beat_s && ((blk_cnt_r == {NBW{1'b0}}) || cand_better_s)) begin
            acc_val_s = core_val_s;
            acc_idx_s = cand_idx_s;
        end else begin
            acc_val_s = acc_val_r;
            acc_idx_s = acc_idx_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_s = RUN;
                else            state_s = IDLE;
            end
            RUN: begin
                if (beat_s && last_s) state_s = DONE;
                else                  state_s = RUN;
            end
            DONE: begin
                if (m_ready) state_s = IDLE;
                else         state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Registered handshakes, captured config, counter, accumulator and result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_ready_r  <= 1'b0;
            m_valid_r  <= 1'b0;
            busy_r     <= 1'b0;
            nblk_r     <= {NBW{1'b0}};
            blk_cnt_r  <= {NBW{1'b0}};
            us_r       <= 1'b0;
            mm_r       <= 1'b0;
            acc_val_r  <= {W{1'b0}};
            acc_idx_r  <= {GIDXW{1'b0}};
            m_result_r <= {W{1'b0}};
            m_index_r  <= {GIDXW{1'b0}};
        end else begin
            s_ready_r <= (state_s == RUN);
            m_valid_r <= (state_s == DONE);
            busy_r    <= (state_s != IDLE);
            acc_val_r <= acc_val_s;
            acc_idx_r <= acc_idx_s;
            if ((state_r == IDLE) && start_ok_s) begin
                nblk_r    <= cfg_nblk;
                us_r      <= cfg_us_sel;
                mm_r      <= cfg_min_max_sel;
                blk_cnt_r <= {NBW{1'b0}};
            end else if (beat_s) begin
                blk_cnt_r <= blk_cnt_r + NBW'(1'b1);
            end
            if (beat_s && last_s) begin
                m_result_r <= acc_val_s;
                m_index_r  <= acc_idx_s;
            end
        end
    end

    assign s_ready  = s_ready_r;
    assign m_valid  = m_valid_r;
    assign busy     = busy_r;
    assign m_result = m_result_r;
    assign m_index  = m_index_r;
endmodule

// File: tb/tb_minmax_frame_ctrl.sv
// Self-checking bench for minmax_frame_ctrl: directed scenarios plus random
// frames compared against a flat whole-frame extremum scan.

module tb_minmax_frame_ctrl;
    localparam int W        = 5;
    localparam int NI       = 9;
    localparam int NBLK_MAX = 16;
    localparam int GIDXW    = $clog2(NI*NBLK_MAX);
    localparam int NBW      = $clog2(NBLK_MAX) + 1;
    localparam int DW       = NI*W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_start;
    logic [NBW-1:0]   cfg_nblk;
    logic             cfg_us_sel;
    logic             cfg_min_max_sel;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_result;
    logic [GIDXW-1:0] m_index;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] blk_mem [NBLK_MAX];

    always #5 clk = ~clk;

    minmax_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_nblk(cfg_nblk),
        .cfg_us_sel(cfg_us_sel), .cfg_min_max_sel(cfg_min_max_sel),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
        .m_index(m_index), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int as_num(input logic [W-1:0] v, input logic us);
        if (us && v[W-1]) return int'(v) - (1 << W);
        return int'(v);
    endfunction

    // Reference: scan all elements in global order, replace only on strict improvement.
    task automatic model(input int nblk, input logic us, input logic mm,
                         output logic [W-1:0] res, output logic [GIDXW-1:0] idx);
        int best_g;
        int best_v;
        best_g = 0;
        best_v = as_num(blk_mem[0][W-1:0], us);
        for (int g = 1; g < nblk*NI; g++) begin
            int v;
            v = as_num(blk_mem[g/NI][(g%NI)*W +: W], us);
            if (mm ? (v > best_v) : (v < best_v)) begin
                best_v = v;
                best_g = g;
            end
        end
        res = W'(best_v);
        idx = GIDXW'(best_g);
    endtask

    task automatic fill(input int b, input logic [W-1:0] v);
        for (int k = 0; k < NI; k++) blk_mem[b][k*W +: W] = v;
    endtask

    task automatic fill_nonzero(input int b);
        for (int k = 0; k < NI; k++) blk_mem[b][k*W +: W] = W'($urandom_range(1, 31));
    endtask

    // Starts a frame, scrambles cfg afterwards, streams blocks with gaps, samples after last beat.
    task automatic drive_frame(input int nblk, input logic us, input logic mm, input int gap,
                               output logic rdy_after_start, output logic timeout,
                               output logic mv, output logic [W-1:0] res,
                               output logic [GIDXW-1:0] idx);
        timeout         = 1'b0;
        cfg_start       = 1'b1;
        cfg_nblk        = NBW'(nblk);
        cfg_us_sel      = us;
        cfg_min_max_sel = mm;
        step();
        cfg_start       = 1'b0;
        cfg_nblk        = NBW'($urandom_range(0, 31));
        cfg_us_sel      = 1'($urandom);
        cfg_min_max_sel = 1'($urandom);
        rdy_after_start = s_ready;
        for (int b = 0; b < nblk; b++) begin
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                s_data  = DW'({$urandom, $urandom});
                step();
            end
            s_valid = 1'b1;
            s_data  = blk_mem[b];
            for (int w = 0; w < 20 && !s_ready; w++) step();
            if (!s_ready) timeout = 1'b1;
            step();
            s_valid = 1'b0;
            s_data  = DW'({$urandom, $urandom});
        end
        mv  = m_valid;
        res = m_result;
        idx = m_index;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_start = 1'b0; cfg_nblk = '0; cfg_us_sel = 1'b0;
        cfg_min_max_sel = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step(); step();
        n_cmp++;
        if ({s_ready, m_valid, busy, m_result, m_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b mv=%b busy=%b res=%0d idx=%0d, expected all 0",
                     s_ready, m_valid, busy, m_result, m_index);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_unsigned_tie();
        logic rdy, to, mv;
        logic [W-1:0] res, eres;
        logic [GIDXW-1:0] idx, eidx;
        fill(0, 5'd20); blk_mem[0][3*W +: W] = 5'd4;
        fill(1, 5'd10); blk_mem[1][5*W +: W] = 5'd4;
        model(2, 1'b0, 1'b0, eres, eidx);
        drive_frame(2, 1'b0, 1'b0, 0, rdy, to, mv, res, idx);
        n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL tie_s_ready: got %b expected 1", rdy); end
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL tie_timeout: got %b expected 0", to); end
        n_cmp++; if (mv !== 1'b1) begin n_fail++; $display("FAIL tie_latency: m_valid=%b expected 1", mv); end
        n_cmp++; if (res !== 5'd4 || res !== eres) begin n_fail++; $display("FAIL tie_result: got %0d expected 4", res); end
        n_cmp++; if (idx !== 8'd3 || idx !== eidx) begin n_fail++; $display("FAIL tie_index: got %0d expected 3", idx); end
        m_ready = 1'b1; step(); m_ready = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tie_handshake: mv=%b busy=%b expected 0 0", m_valid, busy);
        end
    endtask

    task automatic test_signed_max();
        logic rdy, to, mv;
        logic [W-1:0] res;
        logic [GIDXW-1:0] idx;
        fill(0, 5'h10);
        fill(1, 5'd3);  blk_mem[1][0 +: W] = 5'd14;
        fill(2, 5'd0);  blk_mem[2][8*W +: W] = 5'd15;
        drive_frame(3, 1'b1, 1'b1, 0, rdy, to, mv, res, idx);
        n_cmp++; if (mv !== 1'b1) begin n_fail++; $display("FAIL smax_valid: got %b expected 1", mv); end
        n_cmp++; if (res !== 5'd15) begin n_fail++; $display("FAIL smax_result: got %0d expected 15", res); end
        n_cmp++; if (idx !== 8'd26) begin n_fail++; $display("FAIL smax_index: got %0d expected 26", idx); end
        m_ready = 1'b1; step(); m_ready = 1'b0;
        drive_frame(3, 1'b0, 1'b1, 0, rdy, to, mv, res, idx);
        n_cmp++; if (res !== 5'h10) begin n_fail++; $display("FAIL umax_result: got %0d expected 16", res); end
        n_cmp++; if (idx !== 8'd0) begin n_fail++; $display("FAIL umax_index: got %0d expected 0", idx); end
        m_ready = 1'b1; step(); m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic rdy, to, mv;
        logic [W-1:0] res, eres;
        logic [GIDXW-1:0] idx, eidx;
        for (int b = 0; b < 3; b++) fill_nonzero(b);
        model(3, 1'b0, 1'b1, eres, eidx);
        drive_frame(3, 1'b0, 1'b1, 0, rdy, to, mv, res, idx);
        for (int c = 0; c < 5; c++) begin
            cfg_start = (c == 2);
            cfg_nblk  = NBW'(2);
            step();
            n_cmp++;
            if (m_valid !== 1'b1 || m_result !== eres || m_index !== eidx || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: mv=%b res=%0d idx=%0d rdy=%b expected 1 %0d %0d 0",
                         c, m_valid, m_result, m_index, s_ready, eres, eidx);
            end
        end
        cfg_start = 1'b0;
        m_ready = 1'b1; step(); m_ready = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: mv=%b busy=%b expected 0 0", m_valid, busy);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_queue: busy=%b expected 0", busy); end
    endtask

    task automatic test_gaps();
        logic rdy, to, mv;
        logic [W-1:0] res, eres;
        logic [GIDXW-1:0] idx, eidx;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < NI; k++) blk_mem[b][k*W +: W] = W'($urandom_range(0, 7));
        model(4, 1'b0, 1'b0, eres, eidx);
        for (int pass = 0; pass < 2; pass++) begin
            drive_frame(4, 1'b0, 1'b0, (pass == 0) ? 3 : 0, rdy, to, mv, res, idx);
            n_cmp++;
            if (mv !== 1'b1 || res !== eres || idx !== eidx || to !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps[%0d]: mv=%b res=%0d idx=%0d expected 1 %0d %0d", pass, mv, res, idx, eres, eidx);
            end
            m_ready = 1'b1; step(); m_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        logic rdy, to, mv;
        logic [W-1:0] res;
        logic [GIDXW-1:0] idx;
        cfg_start = 1'b1; cfg_nblk = NBW'(4); cfg_us_sel = 1'b0; cfg_min_max_sel = 1'b1;
        step();
        cfg_start = 1'b0; s_valid = 1'b1; s_data = DW'({$urandom, $urandom});
        step();
        s_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({s_ready, m_valid, busy, m_result, m_index} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy=%b mv=%b busy=%b res=%0d idx=%0d expected all 0",
                     s_ready, m_valid, busy, m_result, m_index);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: busy=%b mv=%b expected 0 0", busy, m_valid);
        end
        fill_nonzero(0); blk_mem[0][7*W +: W] = 5'd0;
        drive_frame(1, 1'b0, 1'b0, 0, rdy, to, mv, res, idx);
        n_cmp++;
        if (mv !== 1'b1 || res !== 5'd0 || idx !== 8'd7) begin
            n_fail++; $display("FAIL midreset_frame: mv=%b res=%0d idx=%0d expected 1 0 7", mv, res, idx);
        end
        m_ready = 1'b1; step(); m_ready = 1'b0;
    endtask

    task automatic test_config_edges();
        logic rdy, to, mv;
        logic [W-1:0] res;
        logic [GIDXW-1:0] idx;
        for (int t = 0; t < 2; t++) begin
            cfg_start = 1'b1;
            cfg_nblk  = (t == 0) ? NBW'(0) : NBW'(NBLK_MAX + 1);
            step();
            cfg_start = 1'b0;
            step();
            n_cmp++;
            if (busy !== 1'b0 || s_ready !== 1'b0) begin
                n_fail++; $display("FAIL bad_nblk[%0d]: busy=%b rdy=%b expected 0 0", t, busy, s_ready);
            end
        end
        for (int b = 0; b < NBLK_MAX; b++) fill_nonzero(b);
        blk_mem[15][8*W +: W] = 5'd0;
        drive_frame(NBLK_MAX, 1'b0, 1'b0, 0, rdy, to, mv, res, idx);
        n_cmp++;
        if (mv !== 1'b1 || res !== 5'd0 || idx !== 8'd143) begin
            n_fail++; $display("FAIL max_nblk: mv=%b res=%0d idx=%0d expected 1 0 143", mv, res, idx);
        end
        m_ready = 1'b1; step(); m_ready = 1'b0;
    endtask

    task automatic test_random();
        logic rdy, to, mv, us, mm;
        logic [W-1:0] res, eres;
        logic [GIDXW-1:0] idx, eidx;
        int nblk, dly;
        for (int f = 0; f < 25; f++) begin
            nblk = $urandom_range(1, NBLK_MAX);
            us   = 1'($urandom);
            mm   = 1'($urandom);
            for (int b = 0; b < nblk; b++)
                for (int k = 0; k < NI; k++) begin
                    logic [W-1:0] e;
                    e = W'($urandom_range(0, 31));
                    if ($urandom_range(0, 1) == 1) e = e & 5'b10001;
                    blk_mem[b][k*W +: W] = e;
                end
            model(nblk, us, mm, eres, eidx);
            drive_frame(nblk, us, mm, $urandom_range(0, 2), rdy, to, mv, res, idx);
            n_cmp++;
            if (mv !== 1'b1 || res !== eres || idx !== eidx || to !== 1'b0) begin
                n_fail++;
                $display("FAIL rand[%0d] nblk=%0d us=%b mm=%b: mv=%b res=%0d idx=%0d expected 1 %0d %0d",
                         f, nblk, us, mm, mv, res, idx, eres, eidx);
            end
            dly = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) step();
            n_cmp++;
            if (m_valid !== 1'b1 || m_index !== eidx) begin
                n_fail++; $display("FAIL rand_hold[%0d]: mv=%b idx=%0d expected 1 %0d", f, m_valid, m_index, eidx);
            end
            m_ready = 1'b1; step(); m_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_tie();
        test_signed_max();
        test_backpressure();
        test_gaps();
        test_reset_midframe();
        test_config_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
